// File: rtl/arb_mux_n.sv
// N-input to 1-output channel mux with explicit-select or round-robin grant,
// feeding a single registered output stage with valid/ready handshake.
module arb_mux_n #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 16,
    parameter int MODE       = 0,
    localparam int SEL_W     = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]            in_valid,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic [SEL_W-1:0]             sel,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_W-1:0]             out_src
);

    // One extra bit so ptr + offset and NUM_IN itself are representable.
    localparam int              CW       = SEL_W + 1;
    localparam logic [CW-1:0]   NUM_IN_C = CW'(NUM_IN);

    logic                  load;
    logic                  xfer;
    logic                  gvalid;
    logic [SEL_W-1:0]      gidx;
    logic [NUM_IN-1:0]     grant;
    logic [SEL_W-1:0]      ptr;
    logic [SEL_W-1:0]      ptr_next;
    logic [SEL_W-1:0]      rr_idx;
    logic                  rr_found;
    logic [CW-1:0]         cand;
    logic [DATA_WIDTH-1:0] sel_data;

    assign load = !out_valid || out_ready;

    // Search ptr, ptr+1, ... modulo NUM_IN for the first valid channel.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= NUM_IN_C) begin
                cand = cand - NUM_IN_C;
            end
            if (!rr_found && in_valid[cand[SEL_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = cand[SEL_W-1:0];
            end
        end
    end

    always_comb begin
        gidx   = '0;
        gvalid = 1'b0;
        if (MODE == 1) begin
            gidx   = rr_idx;
            gvalid = rr_found;
        end else begin
            gidx   = sel;
            gvalid = ({1'b0, sel} < NUM_IN_C);
        end
    end

    always_comb begin
        grant = '0;
        if (gvalid) begin
            grant[gidx] = 1'b1;
        end
    end

    // Gated by rst_n so in_ready drops the moment reset asserts.
    assign in_ready = grant & {NUM_IN{load & rst_n}};
    assign xfer     = gvalid && load && in_valid[gidx];
    assign sel_data = in_data[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign ptr_next = ({1'b0, gidx} == (NUM_IN_C - CW'(1))) ? '0 : gidx + SEL_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_src   <= '0;
            ptr       <= '0;
        end else begin
            if (load) begin
                out_valid <= xfer;
                if (xfer) begin
                    out_data <= sel_data;
                    out_src  <= gidx;
                end
            end
            if (xfer && (MODE == 1)) begin
                ptr <= ptr_next;
            end
        end
    end

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each data channel in bits.
REQ-002 SHALL have parameter NUM_IN, default 16, legal range 2..64: number of input channels.
REQ-003 SHALL have parameter MODE, default 0: 0 = explicit select, 1 = round-robin arbitration.
REQ-004 SHALL derive local SEL_W = clog2(NUM_IN), with a minimum of 1.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port in_data, input, NUM_IN*DATA_WIDTH bits: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port in_valid, input, NUM_IN bits: per-channel data-valid.
REQ-009 SHALL have port in_ready, output, NUM_IN bits: per-channel accept; combinational.
REQ-010 SHALL have port sel, input, SEL_W bits: channel select, used only when MODE=0.
REQ-011 SHALL have port out_data, output, DATA_WIDTH bits: registered selected data.
REQ-012 SHALL have port out_valid, output, 1 bit: registered output-valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-014 SHALL have port out_src, output, SEL_W bits: registered index of the channel that supplied out_data.

Function
REQ-015 SHALL hold a single output register stage (out_data, out_valid, out_src); "load" = !out_valid || out_ready.
REQ-016 SHALL compute a one-hot grant each cycle; in_ready[i] = grant[i] && load; all other in_ready bits SHALL be 0.
REQ-017 SHALL treat a transfer on channel i as in_valid[i] && in_ready[i]; on a transfer it SHALL register out_data = channel i data, out_src = i, and out_valid = 1.
REQ-018 SHALL, on a load cycle with no transfer, register out_valid = 0 and leave out_data and out_src unchanged.
REQ-019 SHALL hold out_data, out_valid, and out_src stable while out_valid && !out_ready.
REQ-020 SHALL give a latency of 1 cycle from input transfer to out_valid; throughput SHALL be 1 transfer per cycle when out_ready is held at 1.
REQ-021 SHALL, in MODE=0, grant channel sel only when sel < NUM_IN; for sel >= NUM_IN there SHALL be no grant and no transfer.
REQ-022 SHALL, in MODE=0, not require sel to be stable beyond the transfer cycle; sel SHALL be sampled only on that cycle.
REQ-023 SHALL, in MODE=1, ignore sel and keep a priority pointer ptr (SEL_W bits); the grant goes to the first channel with in_valid=1 searching ptr, ptr+1, ..., wrapping modulo NUM_IN.
REQ-024 SHALL, in MODE=1, set ptr = (granted index + 1) mod NUM_IN on every transfer, wrapping NUM_IN-1 to 0; ptr SHALL be unchanged when there is no transfer.
REQ-025 SHALL, in MODE=1, grant a channel only while its in_valid = 1, and the grant SHALL not change within a cycle because in_ready changes.
REQ-026 SHALL, when an output is consumed and a new input transfers in the same cycle, register the new data with out_valid staying 1 and no bubble.
REQ-027 SHALL not make in_ready depend combinationally on any in_data value.

Reset
REQ-028 SHALL, while rst_n = 0, immediately force out_valid = 0, out_data = 0, out_src = 0, ptr = 0, and in_ready all 0.
REQ-029 SHALL discard any held output word on reset asserted mid-transfer; no transfer SHALL be reported.
REQ-030 SHALL allow the first transfer on the first rising clk edge after rst_n deasserts.

Verification
REQ-031 SHALL cover: MODE=0, NUM_IN=16, sel=5, in_valid[5]=1, data 0xA5A5_0005, out_ready=1 -> next cycle out_data=0xA5A5_0005, out_src=5, out_valid=1.
REQ-032 SHALL cover: MODE=0, sel=3, out_valid=1, out_ready=0 for 4 cycles while channel 3 data changes -> out_data held, in_ready=0; out_ready=1 -> new word loaded with no bubble.
REQ-033 SHALL cover: MODE=1, NUM_IN=4, all in_valid=1, out_ready=1 -> out_src sequence 0,1,2,3,0,1, one transfer per cycle.
REQ-034 SHALL cover: MODE=1, ptr=3, only in_valid[1]=1 -> grant to 1 via wrap, then ptr=2.
REQ-035 SHALL cover: MODE=0, NUM_IN=12, sel=13 with all in_valid=1 -> in_ready=0 and out_valid stays 0.
REQ-036 SHALL cover: rst_n pulled low mid-stream with out_valid=1 -> out_valid=0 and in_ready=0 within the same cycle without a clock edge; after release, ptr=0 and the first grant goes to channel 0.
